// File: rtl/fetch_pkg.sv
// Shared widths and the instruction-buffer entry type for the fetch stage.
package fetch_pkg;

    localparam int DATAW      = 32;
    localparam int ADDRW      = 16;
    localparam int FIFO_DEPTH = 4;
    // One extra bit so counters can hold the value FIFO_DEPTH itself.
    localparam int CNTW       = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [DATAW-1:0] instr;
        logic [ADDRW-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and decode.
// Head entry is presented combinationally; reads as zero when empty.
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  fetch_entry_t    wdata,
    input  logic            pop,
    input  logic            flush,
    output fetch_entry_t    rdata,
    output logic [CNTW-1:0] count,
    output logic            empty,
    output logic            full
);

    localparam int              PTRW      = $clog2(FIFO_DEPTH);
    localparam logic [CNTW-1:0] DEPTH_CNT = CNTW'(FIFO_DEPTH);

    fetch_entry_t    mem [FIFO_DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_CNT);
    // Flush wins over both push and pop in the same cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNTW'(do_push) - CNTW'(do_pop);
        end
    end

    // Entry storage written on push.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; validity is tracked by count alone.
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited memory requests, response
// tagging and discard after redirect/halt, buffering toward decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDRW-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [ADDRW-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [DATAW-1:0] imem_rdata,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [ADDRW-1:0] branch_target,
    input  logic             halt,
    output logic [DATAW-1:0] instr,
    output logic [ADDRW-1:0] pc_out,
    output logic             instr_valid,
    output logic             halted
);

    localparam logic [CNTW:0] CREDIT_MAX = (CNTW+1)'(FIFO_DEPTH);

    logic [ADDRW-1:0] pc;
    logic [ADDRW-1:0] resp_pc;
    logic [CNTW-1:0]  outstanding;
    logic [CNTW-1:0]  outstanding_next;
    logic [CNTW-1:0]  drop;
    logic [CNTW-1:0]  count;
    logic [CNTW:0]    credit_used;
    logic             empty;
    logic             full;
    logic             redirect;
    logic             flush;
    logic             grant;
    logic             push;
    logic             pop;
    fetch_entry_t     head;
    fetch_entry_t     resp_entry;

    // Branches are ignored once halted; halt overrides a same-cycle branch.
    assign redirect    = branch_taken && !halt && !halted;
    assign flush       = halt || branch_taken;
    // Buffered words plus in-flight requests must never exceed the buffer size.
    assign credit_used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req    = !rst && !halted && !halt && !branch_taken && (credit_used < CREDIT_MAX);
    assign imem_addr   = pc;
    assign grant       = imem_req && imem_gnt;
    assign outstanding_next = outstanding + CNTW'(grant) - CNTW'(imem_rvalid);

    // Responses owed to a discarded request stream are absorbed, never buffered.
    assign push        = imem_rvalid && (drop == '0) && !flush && !halted;
    assign resp_entry  = '{instr: imem_rdata, pc: resp_pc};

    assign instr_valid = !rst && !empty && !halted;
    assign pop         = instr_valid && !stall && !flush;
    assign instr       = head.instr;
    assign pc_out      = head.pc;

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (resp_entry),
        .pop   (pop),
        .flush (flush),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    // PC, response PC, in-flight/discard counters and sticky halt.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            if (halt) begin
                // PC stays put; everything still in flight gets discarded.
                halted <= 1'b1;
                drop   <= outstanding_next;
            end else if (redirect) begin
                pc      <= branch_target;
                resp_pc <= branch_target;
                drop    <= outstanding_next;
            end else begin
                if (grant) pc <= pc + 1'b1;
                if (imem_rvalid && (drop != '0)) drop <= drop - 1'b1;
                if (push) resp_pc <= resp_pc + 1'b1;
            end
        end
    end

    // The credit rule makes a push into a full buffer impossible.
    assert property (@(posedge clk) disable iff (rst) !(push && full))
        else $error("fetch_unit instruction buffer overflow");

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with configurable latency,
// grant throttling and bursty responses; expected PCs queued per scenario.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [ADDRW-1:0] imem_addr, branch_target = '0, pc_out;
    logic [DATAW-1:0] imem_rdata = '0, instr;
    logic             stall = 1'b0, branch_taken = 1'b0, halt = 1'b0;
    logic             instr_valid, halted;

    logic             imem_req2, imem_rvalid2 = 1'b0, instr_valid2, halted2;
    logic [ADDRW-1:0] imem_addr2, pc_out2;
    logic [DATAW-1:0] imem_rdata2 = '0, instr2;

    typedef struct {
        logic [ADDRW-1:0] addr;
        int               due;
    } req_t;

    req_t             pend[$];
    req_t             done_req;
    logic [ADDRW-1:0] exp_q[$];
    logic [ADDRW-1:0] exp2_q[$];
    logic [ADDRW-1:0] mon_exp;
    int               total = 0, bad = 0;
    int               cyc = 0, grant_cnt = 0, pop_cnt = 0;
    int               lat = 1, gnt_limit = 0;
    bit               gnt_rand = 0, rv_rand = 0;
    logic             cap_req2;
    logic [ADDRW-1:0] cap_addr2;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .halt(halt), .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid),
        .halted(halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut2 (
        .clk(clk), .rst(rst), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_gnt(1'b1), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(16'h0000),
        .halt(1'b0), .instr(instr2), .pc_out(pc_out2), .instr_valid(instr_valid2),
        .halted(halted2)
    );

    function automatic logic [DATAW-1:0] mem_word(input logic [ADDRW-1:0] a);
        return {a ^ 16'hA5C3, a};
    endfunction

    // Memory model: record grants at the edge, drive gnt/rvalid 1 time unit later.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            pend.delete();
            grant_cnt = 0;
        end else begin
            if (imem_rvalid && pend.size() != 0) done_req = pend.pop_front();
            if (imem_req && imem_gnt) begin
                pend.push_back('{imem_addr, cyc + lat - 1});
                grant_cnt++;
            end
        end
        #1;
        imem_gnt = !rst && (grant_cnt < gnt_limit) && (!gnt_rand || ($urandom_range(0, 1) == 1));
        if (!rst && pend.size() != 0 && pend[0].due <= cyc && (!rv_rand || ($urandom_range(0, 1) == 1))) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // Fixed one-cycle memory for the second instance (always granting).
    always @(posedge clk) begin
        cap_req2  = imem_req2;
        cap_addr2 = imem_addr2;
        #1;
        imem_rvalid2 = cap_req2 && !rst;
        imem_rdata2  = mem_word(cap_addr2);
    end

    // Scoreboard: every word decode accepts must be the next expected PC.
    always @(negedge clk) begin
        if (rst) begin
            pop_cnt = 0;
        end else if (instr_valid && !stall && !branch_taken && !halt) begin
            pop_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: got pc %h, want none", pc_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (pc_out !== mon_exp || instr !== mem_word(mon_exp)) begin
                    bad++;
                    $display("FAIL pop_order: got pc %h instr %h, want pc %h instr %h",
                             pc_out, instr, mon_exp, mem_word(mon_exp));
                end
            end
        end
    end

    task automatic do_reset(input int l, input int limit, input bit grand, input bit rrand, input bit st);
        @(posedge clk); #1;
        rst = 1'b1; stall = st; branch_taken = 1'b0; halt = 1'b0; branch_target = '0;
        lat = l; gnt_limit = limit; gnt_rand = grand; rv_rand = rrand;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain: %0d entries left, want 0", name, exp_q.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; gnt_limit = 0; lat = 1; gnt_rand = 0; rv_rand = 0; stall = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL post_rst_req: got %b want 1", imem_req); end
        total++; if (imem_addr !== 16'h0000) begin bad++; $display("FAIL post_rst_addr: got %h want 0000", imem_addr); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL post_rst_halted: got %b want 0", halted); end
        total++; if (pc_out !== 16'h0000 || instr !== 32'h0) begin bad++; $display("FAIL empty_outputs: got %h/%h want 0/0", pc_out, instr); end
        repeat (3) @(negedge clk);
        total++; if (imem_addr !== 16'h0000 || instr_valid !== 1'b0) begin bad++; $display("FAIL no_gnt_hold: got addr %h valid %b want 0000 0", imem_addr, instr_valid); end
    endtask

    task automatic test_stream();
        do_reset(1, 12, 0, 0, 0);
        for (int i = 0; i < 12; i++) exp_q.push_back(ADDRW'(i));
        @(negedge clk);
        total++; if (imem_addr !== 16'd0 || instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c0: got addr %h valid %b want 0000 0", imem_addr, instr_valid); end
        @(negedge clk);
        total++; if (imem_addr !== 16'd1 || instr_valid !== 1'b0) begin bad++; $display("FAIL stream_c1: got addr %h valid %b want 0001 0", imem_addr, instr_valid); end
        @(negedge clk);
        total++; if (imem_addr !== 16'd2 || instr_valid !== 1'b1 || pc_out !== 16'd0) begin
            bad++; $display("FAIL stream_c2: got addr %h valid %b pc %h want 0002 1 0000", imem_addr, instr_valid, pc_out);
        end
        wait_drain("stream", 40);
    endtask

    task automatic test_stall();
        do_reset(1, 8, 0, 0, 1);
        for (int i = 0; i < 8; i++) exp_q.push_back(ADDRW'(i));
        repeat (10) @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_credit: got req %b want 0", imem_req); end
        total++; if (instr_valid !== 1'b1 || pc_out !== 16'd0 || instr !== mem_word(16'd0)) begin
            bad++; $display("FAIL stall_head: got valid %b pc %h want 1 0000", instr_valid, pc_out);
        end
        @(posedge clk); #1 stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL stall_release_gap: got valid %b want 1 at step %0d", instr_valid, i); end
        end
        wait_drain("stall", 40);
    endtask

    task automatic test_branch();
        do_reset(3, 5, 0, 0, 0);
        for (int i = 0; i < 5; i++) exp_q.push_back(ADDRW'(i));
        wait_drain("branch_pre", 60);
        for (int i = 0; i < 4; i++) exp_q.push_back(16'h0040 + ADDRW'(i));
        gnt_limit = 7;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (grant_cnt >= 7) break;
        end
        total++; if (grant_cnt != 7) begin bad++; $display("FAIL branch_setup_grants: got %0d want 7", grant_cnt); end
        branch_taken = 1'b1; branch_target = 16'h0040; gnt_limit = 11;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL branch_cycle_req: got %b want 0", imem_req); end
        @(posedge clk); #1 branch_taken = 1'b0;
        @(negedge clk);
        total++; if (imem_addr !== 16'h0040 || imem_req !== 1'b1) begin
            bad++; $display("FAIL branch_target_req: got addr %h req %b want 0040 1", imem_addr, imem_req);
        end
        wait_drain("branch", 60);
    endtask

    task automatic test_halt_branch();
        do_reset(3, 7, 0, 0, 0);
        for (int i = 0; i < 7; i++) exp_q.push_back(ADDRW'(i));
        wait_drain("halt_pre", 60);
        gnt_limit = 9;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (grant_cnt >= 9) break;
        end
        total++; if (imem_addr !== 16'd9) begin bad++; $display("FAIL halt_setup_pc: got %h want 0009", imem_addr); end
        halt = 1'b1; branch_taken = 1'b1; branch_target = 16'h0080; gnt_limit = 1000;
        @(negedge clk);
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL halt_cycle_req: got %b want 0", imem_req); end
        @(posedge clk); #1 halt = 1'b0; branch_taken = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++; if (halted !== 1'b1) begin bad++; $display("FAIL halted_sticky: got %b want 1", halted); end
            total++; if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
                bad++; $display("FAIL halted_quiet: got valid %b req %b want 0 0", instr_valid, imem_req);
            end
            total++; if (pc_out === 16'h0080 || imem_addr !== 16'd9) begin
                bad++; $display("FAIL halt_pc: got pc_out %h addr %h want pc_out!=0080 addr 0009", pc_out, imem_addr);
            end
        end
        total++; if (pend.size() != 0 || grant_cnt != 9) begin
            bad++; $display("FAIL halt_absorb: got pending %0d grants %0d want 0 9", pend.size(), grant_cnt);
        end
    endtask

    task automatic test_bursty();
        do_reset(1, 40, 1, 1, 0);
        for (int i = 0; i < 40; i++) exp_q.push_back(ADDRW'(i));
        for (int i = 0; i < 800 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            stall = ($urandom_range(0, 3) == 0);
            total++; if (grant_cnt - pop_cnt > FIFO_DEPTH || grant_cnt < pop_cnt) begin
                bad++; $display("FAIL bursty_credit: got inflight %0d want 0..%0d", grant_cnt - pop_cnt, FIFO_DEPTH);
            end
        end
        stall = 1'b0;
        wait_drain("bursty", 20);
    endtask

    task automatic test_pc_wrap();
        do_reset(1, 0, 0, 0, 0);
        exp2_q = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 20 && exp2_q.size() != 0; i++) begin
            @(negedge clk);
            if (instr_valid2) begin
                mon_exp = exp2_q.pop_front();
                total++; if (pc_out2 !== mon_exp || instr2 !== mem_word(mon_exp)) begin
                    bad++; $display("FAIL wrap_seq: got pc %h instr %h want pc %h instr %h", pc_out2, instr2, mon_exp, mem_word(mon_exp));
                end
            end
        end
        total++; if (exp2_q.size() != 0 || halted2 !== 1'b0) begin
            bad++; $display("FAIL wrap_done: got left %0d halted %b want 0 0", exp2_q.size(), halted2);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_halt_branch();
        test_bursty();
        test_pc_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
